rob_commit_stage: RTL
=====================

# rob_commit_stage

In-order commit stage directly downstream of the reorder-buffer stage. It accepts the ROB head entry when valid and latches it. It performs any load or store through a request/acknowledge data-memory port, with byte lanes and load extension. It then writes the selected result to the register file and pulses `pop` so the ROB retires its head. At most one entry is in flight.

## Interface
Parameters:
- `WAIT_MAX`, 15: maximum cycles in REQ without `dmem_ack` before the access is abandoned (1..255).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  **asynchronous, active-high reset**.
- `valid`  in  1  ROB head entry is valid and committable.
- `regWriteR`, `memWriteR`  in  1 each  head entry control bits.
- `resultSrcR`  in  2  result select: 00 EX_result, 01 load data, 10 PC+4, 11 reserved (treated as 00).
- `loadR`  in  3  load type: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; others are treated as none.
- `storeR`  in  2  store type: 00 none, 01 SB, 10 SH, 11 SW.
- `r_WAR`  in  5  destination register.
- `EX_resultR`  in  32  ALU result, also the memory address.
- `mem_WDR`  in  32  store data.
- `PC_plus4R`  in  32  link value.
- `pop`  out  1  one-cycle retire pulse to the ROB.
- `busy`  out  1  asserted whenever the state is not IDLE.
- `dmem_req`, `dmem_we`  out  1 each  memory request and write enable.
- `dmem_addr`  out  32  word-aligned address ({addr[31:2],2'b00}).
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_ack`  in  1  memory accepts or completes the request.
- `dmem_rdata`  in  32  read word, valid while `dmem_ack`=1.
- `rf_we`  out  1  register-file write enable.
- `rf_wa`  out  5  register-file write address.
- `rf_wd`  out  32  register-file write data.
- `mem_err`  out  1  sticky flag: a memory access timed out.
- `misalign`  out  1  sticky flag: a misaligned access was detected (macro only; otherwise tied 0).

## Operation
- State machine: IDLE, REQ, WB.
- **IDLE**:
  - If `valid`=1, latch every head field into internal registers.
  - Memory op means `memWriteR`=1 with `storeR`≠00, or `loadR`∈{001..101}.
  - Memory op → REQ. Otherwise → WB.
  - If `valid`=0, stay in IDLE.
- **REQ**:
  - `dmem_req`=1 held constant with `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata` until `dmem_ack`.
  - An ack in the first REQ cycle is legal.
  - On ack, capture aligned and extended load data, then → WB.
  - Wait counter increments each REQ cycle without ack. When it reaches `WAIT_MAX`: set `mem_err`, drop the request, suppress the register write, → WB.
- **WB**:
  - `pop`=1 for exactly one cycle.
  - `rf_we`=1 iff latched regWrite=1, `r_WAR`≠0, and there is no error or misalign suppression.
  - → IDLE.
- Result data is selected by resultSrc. Loads ignore `regWriteR`=0.
- Byte enables:
  - SB: 0001<<a[1:0], data {4{wd[7:0]}}.
  - SH: 0011<<{a[1],1'b0}, data {2{wd[15:0]}}.
  - SW: 1111, data as-is.
  - Loads: 1111.
- Load extract uses a[1:0] for bytes and a[1] for halves. LB/LH sign-extend; LBU/LHU zero-extend.
- Sticky flags clear only on `rst`.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, wait counter 0, latched entry 0.
- Reset mid-REQ aborts immediately: `dmem_req` drops asynchronously and nothing is popped.
- Non-memory entry: `valid` sampled at edge N, `pop` and `rf_we` high in cycle N+1. Throughput is one entry per 2 cycles.
- Memory entry with ack k cycles after REQ entry (k≥0): `pop` appears k+2 cycles after capture.
- `valid` is ignored outside IDLE. The ROB updates its head on the edge that samples `pop`, so IDLE sees the new head next cycle.
- Timeout: `mem_err` rises in the WB cycle, WAIT_MAX+1 cycles after capture.

## Configuration
- `ROB_COMMIT_MISALIGN_CHK_EN` defined:
  - LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]≠00, skip REQ and go directly to WB.
  - No memory request and no register write.
  - `misalign` is set. `pop` still occurs.
- Undefined:
  - No check is made; offending low address bits are masked (halfword a[0]=0, word a[1:0]=00).
  - `misalign` is tied 0.

## Structure
- Package `rob_commit_pkg`:
  - state enum.
  - LOAD_*/STORE_* encodings.
  - RES_EX/RES_MEM/RES_PC codes.
- Sub-module `mem_lane_align` (combinational): store byte-enable and data replication, load extraction and extension.

## Test plan
- ALU entry, regWrite=1, r_WAR=5, EX_result=0x1234 → `rf_we`=1, `rf_wa`=5, `rf_wd`=0x1234, `pop` one cycle after capture.
- SB addr=0x103, wd=0xAB → `dmem_be`=1000, `dmem_wdata`=0xABABABAB, `dmem_addr`=0x100, `rf_we`=0.
- LB addr=0x102, rdata=0x00800000, ack delayed 3 cycles → `rf_wd`=0xFFFFFF80. Same access with LBU → `rf_wd`=0x80.
- JAL entry with resultSrc=10, PC+4=0x48, r_WAR=0 → `pop`=1, `rf_we`=0.
- No ack with WAIT_MAX=15 → `mem_err`=1 in the WB cycle, `pop`=1, no register write. A following ALU entry still commits normally.
- Macro on, LW addr=0x102 → no `dmem_req`, `misalign`=1, `pop`=1. Assert `rst` during REQ → all outputs 0 at once.

Source files
------------

// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: shared states and field encodings for the commit stage
package rob_commit_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB} state_t;
  localparam logic [2:0] LOAD_NONE = 3'd0, LOAD_LB = 3'd1, LOAD_LH = 3'd2, LOAD_LW = 3'd3, LOAD_LBU = 3'd4, LOAD_LHU = 3'd5;
  localparam logic [1:0] STORE_NONE = 2'd0, STORE_SB = 2'd1, STORE_SH = 2'd2, STORE_SW = 2'd3;
  localparam logic [1:0] RES_EX = 2'd0, RES_MEM = 2'd1, RES_PC = 2'd2;
  function automatic logic is_load(input logic [2:0] l);
    return l != LOAD_NONE && l <= LOAD_LHU;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane enables/replication and load extraction/extension
module mem_lane_align
  import rob_commit_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  store,
  input  logic [31:0] wd,
  input  logic [2:0]  load,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);
  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;
  // lanes follow the low address bits; halfwords use only addr[1], so addr[0] is masked
  always_comb begin
    be = store == STORE_SB ? 4'b0001 << addr : store == STORE_SH ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    wdata = store == STORE_SB ? {4{wd[7:0]}} : store == STORE_SH ? {2{wd[15:0]}} : wd;
    sh = rdata >> {addr, 3'b000};
    b = sh[7:0];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    ldata = load == LOAD_LB  ? {{24{b[7]}}, b} :
            load == LOAD_LH  ? {{16{h[15]}}, h} :
            load == LOAD_LW  ? rdata :
            load == LOAD_LBU ? {24'd0, b} :
            load == LOAD_LHU ? {16'd0, h} : 32'd0;
  end
endmodule

// File: rtl/rob_commit_stage.sv
// rob_commit_stage: in-order commit with data-memory access and writeback; ROB_COMMIT_MISALIGN_CHK_EN enables misalignment trapping
module rob_commit_stage
  import rob_commit_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        regWriteR,
  input  logic        memWriteR,
  input  logic [1:0]  resultSrcR,
  input  logic [2:0]  loadR,
  input  logic [1:0]  storeR,
  input  logic [4:0]  r_WAR,
  input  logic [31:0] EX_resultR,
  input  logic [31:0] mem_WDR,
  input  logic [31:0] PC_plus4R,
  output logic        pop,
  output logic        busy,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        mem_err,
  output logic        misalign
);
  state_t state, state_n;
  logic [7:0] cnt;
  logic reg_write, supp, mis_q, timeout, head_st, head_ld, mis_head;
  logic [1:0] res_src, store_q;
  logic [2:0] load_q;
  logic [4:0] wa;
  logic [31:0] ex_res, wd, pc4, ld_data, ld_val, wd_a, res;
  logic [3:0] be_a;
  assign head_st = memWriteR && storeR != STORE_NONE;
  assign head_ld = is_load(loadR);
`ifdef ROB_COMMIT_MISALIGN_CHK_EN
  assign mis_head = head_st ? (storeR == STORE_SH && EX_resultR[0]) || (storeR == STORE_SW && |EX_resultR[1:0])
                            : ((loadR == LOAD_LH || loadR == LOAD_LHU) && EX_resultR[0]) || (loadR == LOAD_LW && |EX_resultR[1:0]);
  assign misalign = mis_q;
`else
  assign mis_head = 1'b0;
  assign misalign = 1'b0;
`endif
  mem_lane_align u_align (
    .addr(ex_res[1:0]), .store(store_q), .wd(wd), .load(load_q), .rdata(dmem_rdata),
    .be(be_a), .wdata(wd_a), .ldata(ld_val)
  );
  assign timeout = state == S_REQ && !dmem_ack && cnt == 8'(WAIT_MAX - 1);
  // next state and all outputs; memory and regfile ports read 0 outside their active state
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = valid ? ((head_st || head_ld) && !mis_head ? S_REQ : S_WB) : S_IDLE;
      S_REQ:   state_n = dmem_ack || timeout ? S_WB : S_REQ;
      default: state_n = S_IDLE;
    endcase
    busy = state != S_IDLE;
    dmem_req = state == S_REQ;
    dmem_we = dmem_req && store_q != STORE_NONE;
    dmem_addr = dmem_req ? {ex_res[31:2], 2'b00} : 32'd0;
    dmem_be = dmem_req ? be_a : 4'd0;
    dmem_wdata = dmem_we ? wd_a : 32'd0;
    pop = state == S_WB;
    res = res_src == RES_MEM ? ld_data : res_src == RES_PC ? pc4 : ex_res;
    rf_we = pop && (reg_write || load_q != LOAD_NONE) && wa != 5'd0 && !supp;
    rf_wa = pop ? wa : 5'd0;
    rf_wd = pop ? res : 32'd0;
  end
  // state, wait counter, latched head entry, load capture and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      reg_write <= 1'b0;
      res_src <= '0;
      load_q <= '0;
      store_q <= '0;
      wa <= '0;
      ex_res <= '0;
      wd <= '0;
      pc4 <= '0;
      ld_data <= '0;
      supp <= 1'b0;
      mis_q <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == S_REQ && !dmem_ack && !timeout ? cnt + 8'd1 : 8'd0;
      if (state == S_IDLE && valid) begin
        reg_write <= regWriteR;
        res_src <= resultSrcR;
        store_q <= head_st ? storeR : STORE_NONE;
        load_q <= head_st || !head_ld ? LOAD_NONE : loadR;
        wa <= r_WAR;
        ex_res <= EX_resultR;
        wd <= mem_WDR;
        pc4 <= PC_plus4R;
        supp <= mis_head;
        mis_q <= mis_q | mis_head;
      end
      if (state == S_REQ && dmem_ack) ld_data <= ld_val;
      if (timeout) begin
        mem_err <= 1'b1;
        supp <= 1'b1;
      end
    end
  end
endmodule
